wr_stream_packer: RTL and testbench
===================================

Name: wr_stream_packer

Overview:
- Upstream feeder for axi_wr_master's user write port (wr_trig/wr_len/wr_data/wr_data_en/wr_addr/wr_ready/wr_done).
- Accepts a free-running valid/ready word stream and buffers it in an internal FIFO.
- Cuts the buffered words into fixed-length write bursts and issues each burst to axi_wr_master at auto-incrementing, wrapping DDR2 byte addresses.
- Replaces hand-written trigger/counter logic in benches and user designs.

Parameters:
ADDR_WIDTH, 27, address width (ROW 14 + COL 10 + BA 3)
DATA_WIDTH, 16, stream/burst word width; must be a multiple of 8
BURST_LEN, 8, beats per full burst; 1..255
FIFO_DEPTH, 64, buffer words; power of 2, >= BURST_LEN
BASE_ADDR, 0, first burst address and wrap target
ADDR_END, 2**27, exclusive upper address bound; wrap point

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
init_end  in  1  DDR2 initialisation complete; no burst starts while low
s_valid  in  1  stream word valid
s_ready  out  1  stream word accepted when s_valid&s_ready
s_data  in  DATA_WIDTH  stream word
flush  in  1  pulse: allow final partial burst
wr_trig  out  1  burst request, held until wr_ready
wr_len  out  8  beats in current burst
wr_data  out  DATA_WIDTH  current beat (FIFO head, show-ahead)
wr_data_en  in  1  beat consumed this cycle; next beat on next cycle
wr_addr  out  ADDR_WIDTH  byte address of current burst
wr_ready  in  1  axi_wr_master accepts wr_trig
wr_done  in  1  one-cycle pulse: burst finished (B response)
fifo_level  out  log2(FIFO_DEPTH)+1  words buffered
busy  out  1  state != IDLE
underrun  out  1  sticky: wr_data_en with empty FIFO or beyond wr_len

Behaviour:
- Reset: FSM IDLE, FIFO empty, s_ready 0 for the reset cycle then = !full, wr_trig 0, wr_len 0, wr_data 0, wr_addr BASE_ADDR, fifo_level 0, busy 0, underrun 0, flush_pend 0. Async assert, sync release.
- Reset mid-burst discards FIFO contents and any pending burst; no wr_trig after release until the start conditions hold again.
- FIFO:
  - s_ready = !full.
  - Push on s_valid&s_ready.
  - Pop on wr_data_en only in DATA state with level>0.
  - Simultaneous push and pop leaves level unchanged. Push is allowed when full only if a pop occurs in the same cycle; s_ready stays combinational on !full, so such a push is not offered.
  - wr_data = head word; 0 when empty.
- flush pulse sets flush_pend; flush_pend clears in IDLE when level==0.
- FSM:
  - IDLE -> REQ when init_end && (level>=BURST_LEN || (flush_pend && level>0)). On that edge: wr_len <= min(level,BURST_LEN), beat counter <= 0, wr_trig <= 1.
  - REQ: wr_trig held high and wr_len/wr_addr stable. On wr_trig&wr_ready: wr_trig <= 0 -> DATA. wr_data_en in the same cycle as wr_ready is a valid pop.
  - DATA: each valid pop increments the beat counter. At count==wr_len -> WAIT_DONE.
  - WAIT_DONE: on wr_done -> IDLE, with wr_addr <= wr_addr + wr_len*(DATA_WIDTH/8).
  - If the sum is >= ADDR_END, wr_addr <= BASE_ADDR. No split across the wrap; ADDR_END - BASE_ADDR must be a multiple of the full-burst byte size.
  - wr_done coinciding with the last pop: go straight to IDLE with the address update.
  - wr_done in IDLE/REQ: ignored.
  - wr_data_en in IDLE, REQ before wr_ready, WAIT_DONE, or with an empty FIFO: no pop, underrun <= 1.
- Next burst earliest: IDLE one cycle after wr_done, wr_trig on the following edge.
- init_end dropping mid-burst does not abort the burst. It only blocks new bursts.

Test Plan:
- Push words 1..8 after init_end=1, wr_ready tied 1, wr_data_en each cycle in DATA -> one wr_trig, wr_len=8, wr_addr=0, wr_data 1..8 in order. After wr_done, wr_addr=16.
- Stream 1..40 continuously, wr_ready delayed 3 cycles each burst -> 5 bursts at addrs 0,16,32,48,64, data contiguous, wr_trig held until wr_ready, fifo_level never >64, no underrun.
- Push 5 words with no flush -> no wr_trig. Then flush pulse -> wr_len=5, data 1..5, addr 0. After wr_done, flush_pend clear, busy 0.
- Data pushed while init_end=0 -> no wr_trig, FIFO fills to 64, s_ready=0. init_end=1 -> bursts drain and s_ready reasserts.
- ADDR_END=48, stream 32 words -> bursts at 0,16,32, then 0 (wrap).
- wr_data_en pulsed in IDLE -> underrun=1, level unchanged. rst asserted mid-DATA -> all outputs at reset values immediately, FIFO empty.

Source files
------------

// File: rtl/wr_stream_packer.sv
// wr_stream_packer: buffers a valid/ready word stream in a FIFO and cuts it into
// fixed-length write bursts for axi_wr_master, at auto-incrementing, wrapping byte addresses.
// rst is expected to be released synchronously to clk by the reset source.
module wr_stream_packer #(
  parameter int unsigned     ADDR_WIDTH = 27,
  parameter int unsigned     DATA_WIDTH = 16,
  parameter int unsigned     BURST_LEN  = 8,
  parameter int unsigned     FIFO_DEPTH = 64,
  parameter longint unsigned BASE_ADDR  = 0,
  parameter longint unsigned ADDR_END   = 64'd1 << ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init_end,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          flush,
  output logic                          wr_trig,
  output logic [7:0]                    wr_len,
  output logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_data_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic                          wr_ready,
  input  logic                          wr_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          underrun
);

  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = PW + 1;
  localparam int unsigned BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StReq, StData, StWaitDone} state_e;

  state_e                  state_q, state_d;
  logic                    trig_q, trig_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    flush_pend_q, flush_pend_d;
  logic                    underrun_q, underrun_d;

  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PW:0]             wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]           level;
  logic                    full, empty, push, pop;
  logic [63:0]             addr_sum;
  logic [ADDR_WIDTH-1:0]   addr_next;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  // Held low while reset is asserted so no word is taken during the reset cycle.
  assign s_ready = !rst && !full;
  assign push    = s_valid && s_ready;
  assign wr_data = empty ? '0 : mem[rd_ptr_q[PW-1:0]];

  // Next burst address; wraps to BASE_ADDR instead of splitting a burst across ADDR_END.
  assign addr_sum  = 64'(addr_q) + 64'(len_q) * 64'(BYTES);
  assign addr_next = (addr_sum >= ADDR_END) ? ADDR_WIDTH'(BASE_ADDR) : addr_sum[ADDR_WIDTH-1:0];

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[PW-1:0]] <= s_data;
  end

  // FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Burst sequencing: next state, burst parameters, flush and underrun tracking.
  always_comb begin
    state_d      = state_q;
    trig_d       = trig_q;
    len_d        = len_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    flush_pend_d = flush_pend_q;
    underrun_d   = underrun_q;
    // A beat taken in the same cycle as wr_ready already belongs to the burst.
    pop = wr_data_en && !empty && ((state_q == StData) || (state_q == StReq && wr_ready));
    if (wr_data_en && !pop) underrun_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (init_end && ((level >= LW'(BURST_LEN)) || (flush_pend_q && !empty))) begin
          state_d = StReq;
          trig_d  = 1'b1;
          beat_d  = '0;
          len_d   = (level >= LW'(BURST_LEN)) ? 8'(BURST_LEN) : 8'(level);
        end
      end
      StReq: begin
        if (wr_ready) begin
          trig_d  = 1'b0;
          state_d = StData;
          if (pop) begin
            beat_d = 8'd1;
            if (len_q == 8'd1) state_d = StWaitDone;
          end
        end
      end
      StData: begin
        if (pop) begin
          beat_d = beat_q + 8'd1;
          if (beat_q + 8'd1 == len_q) begin
            if (wr_done) begin
              state_d = StIdle;
              addr_d  = addr_next;
            end else begin
              state_d = StWaitDone;
            end
          end
        end
      end
      StWaitDone: begin
        if (wr_done) begin
          state_d = StIdle;
          addr_d  = addr_next;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) flush_pend_d = 1'b1;
    else if (state_q == StIdle && empty) flush_pend_d = 1'b0;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      trig_q       <= 1'b0;
      len_q        <= '0;
      beat_q       <= '0;
      addr_q       <= ADDR_WIDTH'(BASE_ADDR);
      flush_pend_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_q       <= trig_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      flush_pend_q <= flush_pend_d;
      underrun_q   <= underrun_d;
    end
  end

  assign wr_trig    = trig_q;
  assign wr_len     = len_q;
  assign wr_addr    = addr_q;
  assign fifo_level = level;
  assign busy       = (state_q != StIdle);
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_wr_stream_packer.sv
// Directed bench for wr_stream_packer; a second instance with ADDR_END=48 covers the wrap.
module tb_wr_stream_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_end = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        flush = 1'b0;
  logic        wr_data_en = 1'b0;
  logic        wr_ready = 1'b0;
  logic        wr_done = 1'b0;

  logic        s_ready, wr_trig, busy, underrun;
  logic [7:0]  wr_len;
  logic [15:0] wr_data;
  logic [26:0] wr_addr;
  logic [6:0]  fifo_level;

  logic        w_s_ready, w_wr_trig, w_busy, w_underrun;
  logic [7:0]  w_wr_len;
  logic [15:0] w_wr_data;
  logic [26:0] w_wr_addr;
  logic [6:0]  w_fifo_level;

  int checks = 0;
  int errors = 0;
  int max_level = 0;

  wr_stream_packer dut (
    .clk(clk), .rst(rst), .init_end(init_end), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .flush(flush), .wr_trig(wr_trig), .wr_len(wr_len), .wr_data(wr_data),
    .wr_data_en(wr_data_en), .wr_addr(wr_addr), .wr_ready(wr_ready), .wr_done(wr_done),
    .fifo_level(fifo_level), .busy(busy), .underrun(underrun)
  );

  wr_stream_packer #(.ADDR_END(48)) dut_w (
    .clk(clk), .rst(rst), .init_end(init_end), .s_valid(s_valid), .s_ready(w_s_ready),
    .s_data(s_data), .flush(flush), .wr_trig(w_wr_trig), .wr_len(w_wr_len),
    .wr_data(w_wr_data), .wr_data_en(wr_data_en), .wr_addr(w_wr_addr), .wr_ready(wr_ready),
    .wr_done(wr_done), .fifo_level(w_fifo_level), .busy(w_busy), .underrun(w_underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (int'(fifo_level) > max_level) max_level <= int'(fifo_level);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Offer words first..first+n-1, one per cycle while s_ready.
  task automatic push_words(input int first, input int n);
    int v = first;
    int cyc = 0;
    while (v < first + n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (s_ready) begin
        s_valid = 1'b1;
        s_data  = 16'(v);
        v++;
      end else begin
        s_valid = 1'b0;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("push_count", v - first, n);
  endtask

  task automatic wait_trig();
    int t = 0;
    while (!wr_trig && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("trig_seen", wr_trig, 1);
  endtask

  // Plays axi_wr_master for one burst; addr_w < 0 skips the wrap-instance address check.
  task automatic serve(input int len, input int addr, input int first, input int delay,
                       input int addr_w);
    wait_trig();
    if (!wr_trig) return;
    check("wr_len", wr_len, len);
    check("wr_addr", wr_addr, addr);
    if (addr_w >= 0) check("w_wr_addr", w_wr_addr, addr_w);
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      check("trig_held", wr_trig, 1);
    end
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready = 1'b0;
    for (int i = 0; i < len; i++) begin
      check("wr_data", wr_data, first + i);
      wr_data_en = 1'b1;
      @(negedge clk);
    end
    wr_data_en = 1'b0;
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    init_end = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_wr_trig", wr_trig, 0);
    check("rst_wr_len", wr_len, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_level", fifo_level, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    rst = 1'b0;
    @(negedge clk);
    check("s_ready_after_rst", s_ready, 1);

    // Single full burst
    init_end = 1'b1;
    fork
      push_words(1, 8);
      serve(8, 0, 1, 0, 0);
    join
    check("t1_addr_next", wr_addr, 16);
    check("t1_busy", busy, 0);

    // Continuous stream, delayed wr_ready
    do_reset();
    init_end = 1'b1;
    max_level = 0;
    fork
      push_words(1, 40);
      for (int b = 0; b < 5; b++) serve(8, 16 * b, 1 + 8 * b, 3, -1);
    join
    check("t2_addr_next", wr_addr, 80);
    check("t2_level_bound", max_level <= 64, 1);
    check("t2_underrun", underrun, 0);

    // Partial burst released by flush
    do_reset();
    init_end = 1'b1;
    push_words(1, 5);
    repeat (20) @(negedge clk);
    check("t3_no_trig", wr_trig, 0);
    check("t3_level", fifo_level, 5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    serve(5, 0, 1, 0, 0);
    @(negedge clk);
    check("t3_flush_pend", dut.flush_pend_q, 0);
    check("t3_busy", busy, 0);
    check("t3_addr_next", wr_addr, 10);

    // Fill while DDR2 not initialised, then drain
    do_reset();
    push_words(1, 64);
    repeat (3) @(negedge clk);
    check("t4_level_full", fifo_level, 64);
    check("t4_s_ready_low", s_ready, 0);
    check("t4_no_trig", wr_trig, 0);
    init_end = 1'b1;
    serve(8, 0, 1, 0, -1);
    check("t4_s_ready_back", s_ready, 1);
    for (int b = 1; b < 8; b++) serve(8, 16 * b, 1 + 8 * b, 0, -1);
    check("t4_level_empty", fifo_level, 0);

    // Address wrap (checked on the ADDR_END=48 instance)
    do_reset();
    init_end = 1'b1;
    fork
      push_words(1, 32);
      begin
        serve(8, 0, 1, 1, 0);
        serve(8, 16, 9, 1, 16);
        serve(8, 32, 17, 1, 32);
        serve(8, 48, 25, 1, 0);
      end
    join
    check("t5_w_addr_next", w_wr_addr, 16);
    check("t5_addr_next", wr_addr, 64);

    // wr_data_en in IDLE
    do_reset();
    push_words(1, 3);
    wr_data_en = 1'b1;
    @(negedge clk);
    wr_data_en = 1'b0;
    check("t6_underrun", underrun, 1);
    check("t6_level", fifo_level, 3);
    check("t6_busy", busy, 0);

    // Reset in the middle of a burst
    do_reset();
    check("t7_underrun_cleared", underrun, 0);
    init_end = 1'b1;
    push_words(1, 8);
    wait_trig();
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready = 1'b0;
    wr_data_en = 1'b1;
    repeat (2) @(negedge clk);
    wr_data_en = 1'b0;
    check("t7_mid_busy", busy, 1);
    check("t7_mid_level", fifo_level, 6);
    rst = 1'b1;
    #1;
    check("t7_rst_trig", wr_trig, 0);
    check("t7_rst_len", wr_len, 0);
    check("t7_rst_addr", wr_addr, 0);
    check("t7_rst_data", wr_data, 0);
    check("t7_rst_level", fifo_level, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_s_ready", s_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t7_post_no_trig", wr_trig, 0);
    check("t7_post_level", fifo_level, 0);
    check("t7_post_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
